// File: rtl/imuldiv_mul_arbiter.sv
// Shares one iterative multiplier between two val/rdy requesters (round-robin or fixed priority); optional counters under IMULDIV_ARB_PERF_EN.
// Zero added latency (combinational forwarding); while the owner stalls its response, both request ports see rdy=0.
module imuldiv_mul_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  output logic [63:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] unit_req_msg_a,
  output logic [31:0] unit_req_msg_b,
  output logic        unit_req_val,
  input  logic        unit_req_rdy,
  input  logic [63:0] unit_resp_msg_result,
  input  logic        unit_resp_val,
  output logic        unit_resp_rdy
`ifdef IMULDIV_ARB_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1,
  output logic [31:0] perf_busy
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   win;
  logic   fire;
  logic   done;

  always_comb begin
    // With nobody valid the preferred port still drives the operand bus.
    win = prio_q;
    if (req0_val && !req1_val) begin
      win = 1'b0;
    end else if (!req0_val && req1_val) begin
      win = 1'b1;
    end else if (req0_val && req1_val && (FIXED_PRIO != 0)) begin
      win = 1'b0;
    end

    state_d          = state_q;
    owner_d          = owner_q;
    prio_d           = prio_q;
    fire             = 1'b0;
    done             = 1'b0;
    req0_rdy         = 1'b0;
    req1_rdy         = 1'b0;
    unit_req_val     = 1'b0;
    unit_resp_rdy    = 1'b0;
    resp0_val        = 1'b0;
    resp1_val        = 1'b0;
    resp0_msg_result = '0;
    resp1_msg_result = '0;
    unit_req_msg_a   = win ? req1_msg_a : req0_msg_a;
    unit_req_msg_b   = win ? req1_msg_b : req0_msg_b;

    if (!reset) begin
      if (state_q == IDLE) begin
        unit_req_val = win ? req1_val : req0_val;
        req0_rdy     = !win && unit_req_rdy;
        req1_rdy     = win && unit_req_rdy;
        fire         = unit_req_val && unit_req_rdy;
        if (fire) begin
          owner_d = win;
          state_d = WAIT;
        end
      end else begin
        unit_resp_rdy = owner_q ? resp1_rdy : resp0_rdy;
        if (owner_q) begin
          resp1_val        = unit_resp_val;
          resp1_msg_result = unit_resp_msg_result;
        end else begin
          resp0_val        = unit_resp_val;
          resp0_msg_result = unit_resp_msg_result;
        end
        done = unit_resp_val && unit_resp_rdy;
        if (done) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

`ifdef IMULDIV_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_grant0_d = perf_grant0_q;
    perf_grant1_d = perf_grant1_q;
    perf_busy_d   = perf_busy_q;
    if (fire && !win) perf_grant0_d = perf_grant0_q + 32'd1;
    if (fire && win)  perf_grant1_d = perf_grant1_q + 32'd1;
    if (state_q == WAIT) perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_busy_q   <= '0;
    end else begin
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_busy_q   <= perf_busy_d;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_busy   = perf_busy_q;
`endif

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: round-robin instance (k=0) and fixed-priority instance (k=1), each with a behavioural multiplier.
module tb_imuldiv_mul_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] ra [2][2];
  logic [31:0] rb [2][2];
  logic        rv [2][2];
  logic        rr [2][2];
  logic [63:0] rs [2][2];
  logic        sv [2][2];
  logic        srdy [2][2];

  logic [31:0] ua [2];
  logic [31:0] ub [2];
  logic        uv [2];
  logic        usrdy [2];
  logic        ubusy [2];
  logic        usv [2];
  logic [63:0] ures [2];
  int          ucnt [2];
  int          lat [2];

`ifdef IMULDIV_ARB_PERF_EN
  logic [31:0] pg0 [2];
  logic [31:0] pg1 [2];
  logic [31:0] pb [2];
`endif

  int total = 0;
  int bad = 0;

  // model state
  bit          mbusy [2] = '{0, 0};
  int          mown [2] = '{0, 0};
  int          mprio [2] = '{0, 0};
  logic [63:0] mexp [2];
  int          busycnt [2] = '{0, 0};
  int          hs [4] = '{0, 0, 0, 0};
  logic [63:0] lres [4];
  int          glog0 [$];
  int          glog1 [$];

  imuldiv_mul_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_msg_a(ra[0][0]), .req0_msg_b(rb[0][0]), .req0_val(rv[0][0]), .req0_rdy(rr[0][0]),
    .resp0_msg_result(rs[0][0]), .resp0_val(sv[0][0]), .resp0_rdy(srdy[0][0]),
    .req1_msg_a(ra[0][1]), .req1_msg_b(rb[0][1]), .req1_val(rv[0][1]), .req1_rdy(rr[0][1]),
    .resp1_msg_result(rs[0][1]), .resp1_val(sv[0][1]), .resp1_rdy(srdy[0][1]),
    .unit_req_msg_a(ua[0]), .unit_req_msg_b(ub[0]), .unit_req_val(uv[0]), .unit_req_rdy(!ubusy[0]),
    .unit_resp_msg_result(ures[0]), .unit_resp_val(usv[0]), .unit_resp_rdy(usrdy[0])
`ifdef IMULDIV_ARB_PERF_EN
    , .perf_grant0(pg0[0]), .perf_grant1(pg1[0]), .perf_busy(pb[0])
`endif
  );

  imuldiv_mul_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_msg_a(ra[1][0]), .req0_msg_b(rb[1][0]), .req0_val(rv[1][0]), .req0_rdy(rr[1][0]),
    .resp0_msg_result(rs[1][0]), .resp0_val(sv[1][0]), .resp0_rdy(srdy[1][0]),
    .req1_msg_a(ra[1][1]), .req1_msg_b(rb[1][1]), .req1_val(rv[1][1]), .req1_rdy(rr[1][1]),
    .resp1_msg_result(rs[1][1]), .resp1_val(sv[1][1]), .resp1_rdy(srdy[1][1]),
    .unit_req_msg_a(ua[1]), .unit_req_msg_b(ub[1]), .unit_req_val(uv[1]), .unit_req_rdy(!ubusy[1]),
    .unit_resp_msg_result(ures[1]), .unit_resp_val(usv[1]), .unit_resp_rdy(usrdy[1])
`ifdef IMULDIV_ARB_PERF_EN
    , .perf_grant0(pg0[1]), .perf_grant1(pg1[1]), .perf_busy(pb[1])
`endif
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x;
    logic signed [63:0] y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return 64'(x * y);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // Behavioural iterative multiplier: lat[k] cycles, holds its result until taken.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ubusy[k] <= 1'b0;
        usv[k]   <= 1'b0;
        ucnt[k]  <= 0;
        ures[k]  <= '0;
      end else if (!ubusy[k]) begin
        if (uv[k]) begin
          ubusy[k] <= 1'b1;
          ucnt[k]  <= lat[k];
          ures[k]  <= smul(ua[k], ub[k]);
        end
      end else if (!usv[k]) begin
        if (ucnt[k] <= 1) usv[k] <= 1'b1;
        else ucnt[k] <= ucnt[k] - 1;
      end else if (usrdy[k]) begin
        usv[k]   <= 1'b0;
        ubusy[k] <= 1'b0;
      end
    end
  end

  // Transaction model: one owner at a time, winner chosen from the arbitration rules.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      int o;
      if (reset) begin
        chk("rst_resp0_val", k, 64'(sv[k][0]), 64'd0);
        chk("rst_resp1_val", k, 64'(sv[k][1]), 64'd0);
        chk("rst_unit_val", k, 64'(uv[k]), 64'd0);
        chk("rst_unit_resp_rdy", k, 64'(usrdy[k]), 64'd0);
        chk("rst_msgs_known", k, 64'($isunknown({ua[k], ub[k], rs[k][0], rs[k][1]})), 64'd0);
        mbusy[k] = 1'b0;
        mown[k] = 0;
        mprio[k] = 0;
        busycnt[k] = 0;
      end else if (!mbusy[k]) begin
        if (rv[k][0] && !rv[k][1]) w = 0;
        else if (!rv[k][0] && rv[k][1]) w = 1;
        else if (rv[k][0] && rv[k][1] && k == 1) w = 0;
        else w = mprio[k];
        chk("idle_win_rdy", k, 64'(rr[k][w]), 64'(!ubusy[k]));
        chk("idle_lose_rdy", k, 64'(rr[k][1-w]), 64'd0);
        chk("idle_unit_val", k, 64'(uv[k]), 64'(rv[k][w]));
        chk("idle_unit_a", k, 64'(ua[k]), 64'(ra[k][w]));
        chk("idle_unit_b", k, 64'(ub[k]), 64'(rb[k][w]));
        chk("idle_resp_vals", k, 64'({sv[k][0], sv[k][1]}), 64'd0);
        chk("idle_unit_resp_rdy", k, 64'(usrdy[k]), 64'd0);
        if (rv[k][w] && !ubusy[k]) begin
          mbusy[k] = 1'b1;
          mown[k] = w;
          mexp[k] = smul(ra[k][w], rb[k][w]);
          if (k == 0) glog0.push_back(w);
          else glog1.push_back(w);
        end
      end else begin
        o = mown[k];
        busycnt[k]++;
        chk("wait_req_rdys", k, 64'({rr[k][0], rr[k][1]}), 64'd0);
        chk("wait_unit_val", k, 64'(uv[k]), 64'd0);
        chk("wait_owner_val", k, 64'(sv[k][o]), 64'(usv[k]));
        chk("wait_other_val", k, 64'(sv[k][1-o]), 64'd0);
        chk("wait_unit_resp_rdy", k, 64'(usrdy[k]), 64'(srdy[k][o]));
        if (usv[k]) chk("wait_result_pass", k, rs[k][o], ures[k]);
        if (usv[k] && srdy[k][o]) begin
          chk("resp_product", k, rs[k][o], mexp[k]);
          lres[k*2+o] = rs[k][o];
          hs[k*2+o]++;
          mbusy[k] = 1'b0;
          mprio[k] = 1 - o;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input int k, input int p, input logic [31:0] a, input logic [31:0] b);
    bit fired;
    int n;
    fired = 1'b0;
    n = 0;
    ra[k][p] = a;
    rb[k][p] = b;
    rv[k][p] = 1'b1;
    while (!fired && n < 400) begin
      @(negedge clk); #1;
      if (rr[k][p] === 1'b1) fired = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    rv[k][p] = 1'b0;
    chk("req_fired", k, 64'(fired), 64'd1);
  endtask

  task automatic wait_hs(input int k, input int p, input int target);
    int n;
    n = 0;
    while (hs[k*2+p] < target && n < 400) begin
      tick();
      n++;
    end
    chk("resp_arrived", k, 64'(hs[k*2+p] >= target), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, base, n;
    bit got;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 3;
      for (int p = 0; p < 2; p++) begin
        ra[k][p] = '0; rb[k][p] = '0; rv[k][p] = 1'b0; srdy[k][p] = 1'b1;
      end
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // post-reset idle: prio 0, unit ready
    smp();
    chk("reset_req0_rdy", 0, 64'(rr[0][0]), 64'd1);
    chk("reset_req1_rdy", 0, 64'(rr[0][1]), 64'd0);
    chk("reset_unit_val", 0, 64'(uv[0]), 64'd0);
    tick();

    // single port 0: 3 * -5
    h1 = hs[1];
    send(0, 0, 32'd3, 32'hFFFF_FFFB);
    wait_hs(0, 0, 1);
    chk("t1_result", 0, lres[0], 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t1_no_resp1", 0, 64'(hs[1]), 64'(h1));
    smp();
    chk("t1_idle_prio1_rdy", 0, 64'(rr[0][1]), 64'd1);
    chk("t1_idle_port0_rdy", 0, 64'(rr[0][0]), 64'd0);
    tick();

    // simultaneous after reset: 7*6 and 2*9
    do_reset();
    base = glog0.size();
    h0 = hs[0]; h1 = hs[1];
    fork
      send(0, 0, 32'd7, 32'd6);
      send(0, 1, 32'd2, 32'd9);
    join
    wait_hs(0, 1, h1 + 1);
    chk("t2_grant_count", 0, 64'(glog0.size() - base), 64'd2);
    chk("t2_first_grant", 0, 64'(glog0[base]), 64'd0);
    chk("t2_second_grant", 0, 64'(glog0[base+1]), 64'd1);
    chk("t2_result0", 0, lres[0], 64'd42);
    chk("t2_result1", 0, lres[1], 64'd18);

    // round-robin, continuous requests
    base = glog0.size();
    h0 = hs[0]; h1 = hs[1];
    fork
      begin for (int i = 0; i < 4; i++) send(0, 0, 32'(i + 1), 32'd10); end
      begin for (int i = 0; i < 4; i++) send(0, 1, 32'(i + 1), 32'd100); end
    join
    wait_hs(0, 0, h0 + 4);
    wait_hs(0, 1, h1 + 4);
    chk("t3_grant_count", 0, 64'(glog0.size() - base), 64'd8);
    for (int i = 0; i < 8; i++) chk("t3_rr_order", 0, 64'(glog0[base+i]), 64'(i % 2));
    chk("t3_last0", 0, lres[0], 64'd40);
    chk("t3_last1", 0, lres[1], 64'd400);

    // fixed priority, continuous requests
    base = glog1.size();
    h0 = hs[2]; h1 = hs[3];
    fork
      begin for (int i = 0; i < 4; i++) send(1, 0, 32'(i + 1), 32'd10); end
      begin for (int i = 0; i < 4; i++) send(1, 1, 32'(i + 1), 32'd100); end
    join
    wait_hs(1, 1, h1 + 4);
    chk("t3fp_grant_count", 1, 64'(glog1.size() - base), 64'd8);
    for (int i = 0; i < 8; i++) chk("t3fp_order", 1, 64'(glog1[base+i]), 64'(i >= 4));

    // owner backpressure for 10 cycles
    h0 = hs[0]; h1 = hs[1];
    srdy[0][0] = 1'b0;
    fork
      send(0, 0, 32'd5, 32'd11);
      send(0, 1, 32'd6, 32'd7);
      begin
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
          smp();
          if (sv[0][0] === 1'b1) got = 1'b1;
          else n++;
        end
        chk("bp_val_rise", 0, 64'(got), 64'd1);
        for (int i = 0; i < 10; i++) begin
          chk("bp_val_held", 0, 64'(sv[0][0]), 64'd1);
          chk("bp_result_stable", 0, rs[0][0], 64'd55);
          chk("bp_other_rdy", 0, 64'(rr[0][1]), 64'd0);
          chk("bp_no_xfer", 0, 64'(hs[0]), 64'(h0));
          smp();
        end
        tick();
        srdy[0][0] = 1'b1;
      end
    join
    wait_hs(0, 1, h1 + 1);
    chk("bp_one_xfer", 0, 64'(hs[0]), 64'(h0 + 1));
    chk("bp_result0", 0, lres[0], 64'd55);
    chk("bp_result1", 0, lres[1], 64'd42);

    // reset in the middle of a multiply
    lat[0] = 20;
    h0 = hs[0]; h1 = hs[1];
    send(0, 0, 32'd9, 32'd9);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    smp();
    chk("mid_rst_req0_rdy", 0, 64'(rr[0][0]), 64'd1);
    chk("mid_rst_req1_rdy", 0, 64'(rr[0][1]), 64'd0);
    chk("mid_rst_unit_val", 0, 64'(uv[0]), 64'd0);
    tick();
    repeat (30) tick();
    chk("mid_rst_no_resp0", 0, 64'(hs[0]), 64'(h0));
    chk("mid_rst_no_resp1", 0, 64'(hs[1]), 64'(h1));
    lat[0] = 3;
    send(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_hs(0, 1, h1 + 1);
    chk("mid_rst_fresh_result", 0, lres[1], 64'd1);

`ifdef IMULDIV_ARB_PERF_EN
    do_reset();
    h0 = hs[0]; h1 = hs[1];
    fork
      begin for (int i = 0; i < 3; i++) send(0, 0, 32'(i + 2), 32'd3); end
      begin for (int i = 0; i < 2; i++) send(0, 1, 32'(i + 5), 32'd4); end
    join
    wait_hs(0, 0, h0 + 3);
    wait_hs(0, 1, h1 + 2);
    repeat (2) tick();
    smp();
    chk("perf_grant0", 0, 64'(pg0[0]), 64'd3);
    chk("perf_grant1", 0, 64'(pg1[0]), 64'd2);
    chk("perf_busy_model", 0, 64'(pb[0]), 64'(busycnt[0]));
    chk("perf_busy_literal", 0, 64'(pb[0]), 64'd20);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
